// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the edge detector bank.
package edge_det_pkg;

  // Per-channel edge selection, encoded as the 2-bit field in the mode bus.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // True when the filtered level moving from old_lvl to new_lvl is an edge
  // the channel has been asked to report.
  function automatic logic edge_qualifies(input edge_mode_t mode,
                                          input logic       old_lvl,
                                          input logic       new_lvl);
    logic w_q;
    w_q = 1'b0;
    case (mode)
      EDGE_RISE: w_q = ~old_lvl &  new_lvl;
      EDGE_FALL: w_q =  old_lvl & ~new_lvl;
      EDGE_BOTH: w_q =  old_lvl ^  new_lvl;
      default:   w_q = 1'b0;
    endcase
    return w_q;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, glitch filter, edge classifier and sticky flag.
// There is no valid/ready handshake anywhere in this block: every input is
// sampled on every rising clk edge and every output is a plain level or a
// one-cycle pulse.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_in,
  input  edge_mode_t        mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              clr,
  output logic              level_out,
  output logic              pulse_out,
  output logic              sticky
);

  logic              w_s;
  logic              w_lvl_nxt;
  logic [FILT_W-1:0] w_cnt_nxt;
  logic              w_hit;

  logic              r_lvl;
  logic [FILT_W-1:0] r_cnt;
  logic              r_pulse;
  logic              r_sticky;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      // Input already lives in the clk domain.
      assign w_s = data_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Synchroniser shift chain; reset clears it so a stale level is not seen.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= data_in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Filter next state: accept a new level once it has differed for
  // filt_len+1 consecutive samples. The >= compare lets a shortened
  // filt_len accept a count that is already past it.
  always_comb begin
    w_lvl_nxt = r_lvl;
    w_cnt_nxt = r_cnt;
    if (w_s == r_lvl) begin
      w_cnt_nxt = '0;
    end else if (r_cnt >= filt_len) begin
      w_lvl_nxt = w_s;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + FILT_W'(1);
    end
  end

  // Edge is judged on the filtered level update, never on the raw input.
  assign w_hit = edge_qualifies(mode, r_lvl, w_lvl_nxt);

  // Level, count, pulse and sticky registers; a qualifying edge beats clr.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lvl    <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_lvl    <= w_lvl_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pulse  <= w_hit;
      r_sticky <= w_hit | (r_sticky & ~clr);
    end
  end

  assign level_out = r_lvl;
  assign pulse_out = r_pulse;
  assign sticky    = r_sticky;

endmodule

// File: rtl/edge_detector_bank.sv
// WIDTH independent edge detector channels with a combined interrupt.
module edge_detector_bank
  import edge_det_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     level_out,
  output logic [WIDTH-1:0]     pulse_out,
  output logic [WIDTH-1:0]     sticky,
  output logic                 irq
);

  logic [WIDTH-1:0] w_sticky;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      edge_det_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
      ) u_ch (
        .clk       (clk),
        .resetn    (resetn),
        .data_in   (data_in[i]),
        .mode      (edge_mode_t'(mode[2*i +: 2])),
        .filt_len  (filt_len),
        .clr       (clr[i]),
        .level_out (level_out[i]),
        .pulse_out (pulse_out[i]),
        .sticky    (w_sticky[i])
      );
    end
  endgenerate

  assign sticky = w_sticky;

  // Interrupt is a pure OR of registered sticky bits, so it is glitch-free.
  always_comb begin
    irq = |w_sticky;
  end

endmodule

// File: tb/tb_edge_detector_bank.sv
// Bench for edge_detector_bank: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural model.
module tb_edge_detector_bank;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int FW   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            resetn;
  logic [W-1:0]    data_in;
  logic [2*W-1:0]  mode;
  logic [FW-1:0]   filt_len;
  logic [W-1:0]    clr;
  logic [W-1:0]    level_out;
  logic [W-1:0]    pulse_out;
  logic [W-1:0]    sticky;
  logic            irq;

  always #5 clk = ~clk;

  edge_detector_bank #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC),
    .FILT_W      (FW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .data_in   (data_in),
    .mode      (mode),
    .filt_len  (filt_len),
    .clr       (clr),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .sticky    (sticky),
    .irq       (irq)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw samples taken at previous edges, newest first; a channel sees the
  // sample from SYNC edges ago. Filter modelled as the length of the current
  // run of samples that disagree with the accepted level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_lvl;
  logic [W-1:0] m_pulse;
  logic [W-1:0] m_sticky;
  int           m_run[W];

  task automatic model_step(input logic [W-1:0] din, input logic [2*W-1:0] md,
                            input logic [FW-1:0] fl, input logic [W-1:0] cl,
                            input logic rn);
    logic [W-1:0] s;
    logic [1:0]   mm;
    logic         old_l, new_l, want;
    if (SYNC == 0)                s = din;
    else if (hist.size() >= SYNC) s = hist[SYNC-1];
    else                          s = '0;
    if (!rn) begin
      hist.delete();
      m_lvl = '0; m_pulse = '0; m_sticky = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
      return;
    end
    hist.push_front(din);
    if (hist.size() > SYNC) void'(hist.pop_back());
    for (int c = 0; c < W; c++) begin
      old_l = m_lvl[c];
      new_l = old_l;
      if (s[c] == old_l) begin
        m_run[c] = 0;
      end else begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] > int'(fl)) begin
          new_l    = s[c];
          m_run[c] = 0;
        end
      end
      mm   = md[2*c +: 2];
      want = (mm == 2'b01 && !old_l &&  new_l) ||
             (mm == 2'b10 &&  old_l && !new_l) ||
             (mm == 2'b11 && (old_l != new_l));
      m_lvl[c]   = new_l;
      m_pulse[c] = want;
      if (want)       m_sticky[c] = 1'b1;
      else if (cl[c]) m_sticky[c] = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive on the falling edge, step the model on the rising edge,
  // compare 1 time unit later.
  task automatic tick(input logic [W-1:0] din, input logic [2*W-1:0] md,
                      input logic [FW-1:0] fl, input logic [W-1:0] cl,
                      input logic rn);
    @(negedge clk);
    data_in = din; mode = md; filt_len = fl; clr = cl; resetn = rn;
    @(posedge clk);
    model_step(din, md, fl, cl, rn);
    #1;
    check("level_out", 32'(level_out), 32'(m_lvl));
    check("pulse_out", 32'(pulse_out), 32'(m_pulse));
    check("sticky",    32'(sticky),    32'(m_sticky));
    check("irq",       32'(irq),       32'(|m_sticky));
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0]   din;
  logic [2*W-1:0] md;
  logic [FW-1:0]  fl;
  logic [W-1:0]   cl;
  logic           rn;

  initial begin
    m_lvl = '0; m_pulse = '0; m_sticky = '0;
    for (int c = 0; c < W; c++) m_run[c] = 0;
    data_in = '0; mode = '0; filt_len = '0; clr = '0; resetn = 1'b0;

    // Reset with input 0 held high, rise mode everywhere, no filtering.
    for (int k = 0; k < 3; k++) begin
      tick(8'h01, 16'h5555, 4'd0, 8'h00, 1'b0);
      check("reset_outputs", 32'({level_out, pulse_out, sticky, irq}), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      tick(8'h01, 16'h5555, 4'd0, 8'h00, 1'b1);
      check("post_reset_pulse0", 32'(pulse_out[0]), (k == 2) ? 32'd1 : 32'd0);
    end
    check("post_reset_sticky0", 32'(sticky[0]), 32'd1);
    check("post_reset_irq", 32'(irq), 32'd1);

    // Channel 0 both-edge mode with filt_len=3: settle low, glitch, then a real pulse.
    for (int k = 0; k < 8; k++) tick(8'h00, 16'h0003, 4'd3, 8'hFF, 1'b1);
    for (int k = 0; k < 2; k++) tick(8'h01, 16'h0003, 4'd3, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick(8'h00, 16'h0003, 4'd3, 8'h00, 1'b1);
      check("glitch_no_pulse", 32'(pulse_out[0]), 32'd0);
    end
    check("glitch_level", 32'(level_out[0]), 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick((k < 6) ? 8'h01 : 8'h00, 16'h0003, 4'd3, 8'h00, 1'b1);
      if (k == 5)  check("filt_rise_pulse", 32'(pulse_out[0]), 32'd1);
      if (k == 11) check("filt_fall_pulse", 32'(pulse_out[0]), 32'd1);
      if (k == 4)  check("filt_rise_early", 32'(level_out[0]), 32'd0);
    end

    // Channel 1 fall mode on a period-20 square wave, then mode off.
    for (int k = 0; k < 40; k++)
      tick((((k / 10) % 2) == 0) ? 8'h02 : 8'h00, 16'h0008, 4'd0, 8'h00, 1'b1);
    for (int k = 0; k < 40; k++)
      tick((((k / 10) % 2) == 0) ? 8'h02 : 8'h00, 16'h0000, 4'd0, 8'h00, 1'b1);
    check("mode_off_sticky1", 32'(sticky[1]), 32'd1);

    // Channel 2 rise mode: sticky set, then clr collides with a new pulse.
    for (int k = 0; k < 6; k++) tick(8'h04, 16'h0010, 4'd0, 8'h00, 1'b1);
    for (int k = 0; k < 6; k++) tick(8'h00, 16'h0010, 4'd0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(8'h04, 16'h0010, 4'd0, (k == 2) ? 8'h04 : 8'h00, 1'b1);
      if (k == 2) check("set_beats_clr", 32'(sticky[2]), 32'd1);
    end
    tick(8'h04, 16'h0010, 4'd0, 8'h04, 1'b1);
    check("clr_alone", 32'(sticky[2]), 32'd0);
    for (int k = 0; k < 4; k++) tick(8'h00, 16'h0000, 4'd0, 8'h00, 1'b1);
    tick(8'h00, 16'h0000, 4'd0, 8'hFF, 1'b1);
    check("irq_all_clear", 32'(irq), 32'd0);

    // All channels toggle together with mixed modes.
    for (int k = 0; k < 16; k++) begin
      tick((k < 8) ? 8'hFF : 8'h00, 16'hE4E4, 4'd0, 8'h00, 1'b1);
      if (k == 2)  check("all_rise_pattern", 32'(pulse_out), 32'h000000AA);
      if (k == 10) check("all_fall_pattern", 32'(pulse_out), 32'h000000CC);
    end

    // Reset while channel 3 is part-way through a filt_len=5 count.
    for (int k = 0; k < 4; k++) tick(8'h08, 16'h00C0, 4'd5, 8'h00, 1'b1);
    tick(8'h08, 16'h00C0, 4'd5, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(8'h08, 16'h00C0, 4'd5, 8'h00, 1'b1);
      if (k == 6) check("midfilt_reset_early", 32'(level_out[3]), 32'd0);
      if (k == 7) check("midfilt_reset_accept", 32'(pulse_out[3]), 32'd1);
    end

    // Random traffic: sparse toggles, occasional mode/filter/reset changes.
    din = 8'h08; md = 16'($urandom); fl = 4'd1; rn = 1'b1;
    for (int k = 0; k < 600; k++) begin
      din = din ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) md = 16'($urandom);
      if ($urandom_range(0, 59) == 0) fl = 4'($urandom_range(0, 4));
      cl = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      rn = ($urandom_range(0, 149) != 0);
      tick(din, md, fl, cl, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
